// File: rtl/alu_seq_if.sv
// Request/result bundle between the CPU control sequencer (master) and alu_seq (slave).
// The ALU_DECIMAL_EN build option of alu_seq uses the decimal signal; otherwise it is ignored.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [3:0]         op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [SHAMT_W-1:0] shamt;
    logic               carry_in;
    logic               decimal;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   alu_out;
    logic               carry_out;
    logic               overflow;
    logic               zero;
    logic               sign;

    modport master (
        output in_valid, op, alu_a, alu_b, shamt, carry_in, decimal, out_ready,
        input  in_ready, out_valid, alu_out, carry_out, overflow, zero, sign
    );

    modport slave (
        input  in_valid, op, alu_a, alu_b, shamt, carry_in, decimal, out_ready,
        output in_ready, out_valid, alu_out, carry_out, overflow, zero, sign
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked multi-cycle 6502-style ALU: single-cycle arithmetic/logic, bit-serial shifts/rotates.
// Define ALU_DECIMAL_EN to add the one-cycle BCD adjust state for decimal ADD/SUB.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_EOR = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [3:0] OP_ASL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_ROL = 4'h8;
    localparam logic [3:0] OP_ROR = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
`ifdef ALU_DECIMAL_EN
        , S_BCD = 2'd3
`endif
    } state_t;

    state_t             state_r, state_s;
    logic [3:0]         op_r, op_s;
    logic [WIDTH-1:0]   a_r, a_s, b_r, b_s, res_r, res_s;
    logic [SHAMT_W-1:0] cnt_r, cnt_s;
    logic               cin_r, cin_s, c_r, c_s, v_r, v_s, z_r, z_s, n_r, n_s;
    logic               in_ready_r, in_ready_s, out_valid_r, out_valid_s;
`ifdef ALU_DECIMAL_EN
    logic               dec_r, dec_s;
`endif

    logic               is_shift_s, cin_eff_s, v_arith_s, sh_c_s;
    logic [WIDTH-1:0]   b_eff_s, sh_res_s, flag_s;
    logic [WIDTH:0]     sum_s;

`ifdef ALU_DECIMAL_EN
    // Nibble-serial BCD add/subtract, LSB nibble first; returns {carry, result}.
    function automatic logic [WIDTH:0] bcd_adjust(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic cin, input logic sub);
        logic             c;
        logic [4:0]       t;
        logic [WIDTH-1:0] r;
        c = cin;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH / 4; i++) begin
            if (sub) begin
                t = {1'b0, a[4*i +: 4]} + {1'b0, ~b[4*i +: 4]} + {4'b0000, c};
                c = t[4];
                if (t[4]) r[4*i +: 4] = t[3:0];
                else      r[4*i +: 4] = t[3:0] - 4'd6;
            end else begin
                t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
                if (t > 5'd9) begin
                    t = t + 5'd6;
                    c = 1'b1;
                end else begin
                    c = 1'b0;
                end
                r[4*i +: 4] = t[3:0];
            end
        end
        return {c, r};
    endfunction
`endif

    // Binary sum of the registered operands and the single-bit shift/rotate step.
    always_comb begin
        is_shift_s = (op_r >= OP_ASL) && (op_r <= OP_ROR);
        if (op_r == OP_SUB || op_r == OP_CMP) b_eff_s = ~b_r;
        else                                  b_eff_s = b_r;
        if (op_r == OP_CMP) cin_eff_s = 1'b1;
        else                cin_eff_s = cin_r;
        sum_s     = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_eff_s};
        v_arith_s = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
        // Rotates use carry as the extra bit of a (WIDTH+1)-bit ring.
        case (op_r)
            OP_ASL:  begin sh_c_s = res_r[WIDTH-1]; sh_res_s = {res_r[WIDTH-2:0], 1'b0}; end
            OP_LSR:  begin sh_c_s = res_r[0];       sh_res_s = {1'b0, res_r[WIDTH-1:1]}; end
            OP_ROL:  begin sh_c_s = res_r[WIDTH-1]; sh_res_s = {res_r[WIDTH-2:0], c_r};  end
            OP_ROR:  begin sh_c_s = res_r[0];       sh_res_s = {c_r, res_r[WIDTH-1:1]};  end
            default: begin sh_c_s = c_r;            sh_res_s = res_r;                    end
        endcase
    end

    // Next-state and next-datapath logic of the IDLE/EXEC/[BCD]/DONE sequencer.
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        a_s     = a_r;
        b_s     = b_r;
        cnt_s   = cnt_r;
        cin_s   = cin_r;
        res_s   = res_r;
        c_s     = c_r;
        v_s     = v_r;
        z_s     = z_r;
        n_s     = n_r;
        flag_s  = res_r;
`ifdef ALU_DECIMAL_EN
        dec_s   = dec_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_s = S_EXEC;
                    op_s    = bus.op;
                    a_s     = bus.alu_a;
                    b_s     = bus.alu_b;
                    cnt_s   = bus.shamt;
                    cin_s   = bus.carry_in;
                    res_s   = bus.alu_a;
                    c_s     = bus.carry_in;
`ifdef ALU_DECIMAL_EN
                    dec_s   = bus.decimal;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_EXEC: begin
                if (is_shift_s) begin
                    v_s = 1'b0;
                    if (cnt_r == {SHAMT_W{1'b0}}) begin
                        state_s = S_DONE;
                        flag_s  = res_r;
                    end else begin
                        res_s  = sh_res_s;
                        c_s    = sh_c_s;
                        flag_s = sh_res_s;
                        cnt_s  = cnt_r - SHAMT_W'(1);
                        if (cnt_r == SHAMT_W'(1)) state_s = S_DONE;
                        else                      state_s = S_EXEC;
                    end
                end else begin
                    c_s = 1'b0;
                    v_s = 1'b0;
                    case (op_r)
                        OP_ADD, OP_SUB: begin
                            res_s = sum_s[WIDTH-1:0];
                            c_s   = sum_s[WIDTH];
                            v_s   = v_arith_s;
                        end
                        OP_CMP:  begin res_s = a_r; c_s = sum_s[WIDTH]; end
                        OP_AND:  res_s = a_r & b_r;
                        OP_OR:   res_s = a_r | b_r;
                        OP_EOR:  res_s = a_r ^ b_r;
                        OP_INC:  res_s = a_r + WIDTH'(1);
                        OP_DEC:  res_s = a_r - WIDTH'(1);
                        default: res_s = a_r;
                    endcase
                    if (op_r == OP_CMP) flag_s = sum_s[WIDTH-1:0];
                    else                flag_s = res_s;
`ifdef ALU_DECIMAL_EN
                    if (dec_r && (op_r == OP_ADD || op_r == OP_SUB)) state_s = S_BCD;
                    else                                             state_s = S_DONE;
`else
                    state_s = S_DONE;
`endif
                end
                z_s = (flag_s == {WIDTH{1'b0}});
                n_s = flag_s[WIDTH-1];
            end
`ifdef ALU_DECIMAL_EN
            // V stays as computed from the binary sum in EXEC.
            S_BCD: begin
                {c_s, res_s} = bcd_adjust(a_r, b_r, cin_r, (op_r == OP_SUB));
                z_s          = (res_s == {WIDTH{1'b0}});
                n_s          = res_s[WIDTH-1];
                state_s      = S_DONE;
            end
`endif
            S_DONE: begin
                if (bus.out_ready) state_s = S_IDLE;
                else               state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
        in_ready_s  = (state_s == S_IDLE);
        out_valid_s = (state_s == S_DONE);
    end

    // State, operand and result registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            op_r        <= 4'h0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            cin_r       <= 1'b0;
            res_r       <= {WIDTH{1'b0}};
            c_r         <= 1'b0;
            v_r         <= 1'b0;
            z_r         <= 1'b0;
            n_r         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef ALU_DECIMAL_EN
            dec_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            a_r         <= a_s;
            b_r         <= b_s;
            cnt_r       <= cnt_s;
            cin_r       <= cin_s;
            res_r       <= res_s;
            c_r         <= c_s;
            v_r         <= v_s;
            z_r         <= z_s;
            n_r         <= n_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
`ifdef ALU_DECIMAL_EN
            dec_r       <= dec_s;
`endif
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.alu_out   = res_r;
    assign bus.carry_out = c_r;
    assign bus.overflow  = v_r;
    assign bus.zero      = z_r;
    assign bus.sign      = n_r;
endmodule
